// File: rtl/rob_wr_arbiter.sv
// rob_wr_arbiter: merges short- and long-pipeline writeback packets into the single ROB write port
// Ports:
//   clk, reset (async, active-low)
//   sp_valid/sp_pkt/sp_ready : short-pipeline packet input with its buffer-ready
//   lp_valid/lp_pkt/lp_ready : long-pipeline packet input with its buffer-ready
//   flush                    : synchronous discard of every buffered packet
//   rob_we/rob_pkt/rob_src   : registered ROB write (src 0 = short, 1 = long)
//   conflict_cnt             : saturating count of cycles with both buffers non-empty
module rob_wr_arbiter #(
  parameter int ROB_REGISTER_SIZE = 41,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sp_valid,
  input  logic [ROB_REGISTER_SIZE-1:0] sp_pkt,
  output logic                         sp_ready,
  input  logic                         lp_valid,
  input  logic [ROB_REGISTER_SIZE-1:0] lp_pkt,
  output logic                         lp_ready,
  input  logic                         flush,
  output logic                         rob_we,
  output logic [ROB_REGISTER_SIZE-1:0] rob_pkt,
  output logic                         rob_src,
  output logic [7:0]                   conflict_cnt
);
  localparam int PW = (FIFO_DEPTH == 4) ? 2 : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  logic [ROB_REGISTER_SIZE-1:0] mem_q [2][FIFO_DEPTH];
  logic [ROB_REGISTER_SIZE-1:0] mem_d [2][FIFO_DEPTH];
  logic [ROB_REGISTER_SIZE-1:0] pkt_in [2];
  logic [PW-1:0] wr_ptr_q [2];
  logic [PW-1:0] wr_ptr_d [2];
  logic [PW-1:0] rd_ptr_q [2];
  logic [PW-1:0] rd_ptr_d [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [1:0] valid_in, ready, push, pop, ne;
  logic sel, pop_any;
  logic rr_q, rr_d;
  logic rob_we_q, rob_we_d;
  logic rob_src_q, rob_src_d;
  logic [ROB_REGISTER_SIZE-1:0] rob_pkt_q, rob_pkt_d;
  logic [7:0] conflict_cnt_q, conflict_cnt_d;
  always_comb begin
    valid_in = {lp_valid, sp_valid};
    pkt_in[0] = sp_pkt;
    pkt_in[1] = lp_pkt;
    for (int s = 0; s < 2; s++) begin
      ready[s] = cnt_q[s] < FULL;
      ne[s] = cnt_q[s] != '0;
      push[s] = valid_in[s] && ready[s] && !flush;
    end
    // rr only arbitrates a true conflict; a lone non-empty source always wins
    sel = (ne[0] && ne[1]) ? rr_q : ne[1];
    pop_any = (|ne) && !flush;
    pop = pop_any ? (sel ? 2'b10 : 2'b01) : 2'b00;
    mem_d = mem_q;
    for (int s = 0; s < 2; s++) begin
      wr_ptr_d[s] = flush ? '0 : wr_ptr_q[s] + PW'(push[s]);
      rd_ptr_d[s] = flush ? '0 : rd_ptr_q[s] + PW'(pop[s]);
      cnt_d[s] = flush ? '0 : cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
      if (push[s]) mem_d[s][wr_ptr_q[s]] = pkt_in[s];
    end
    rr_d = flush ? 1'b0 : (pop_any ? ~sel : rr_q);
    rob_we_d = pop_any;
    rob_src_d = pop_any ? sel : rob_src_q;
    rob_pkt_d = pop_any ? mem_q[sel][rd_ptr_q[sel]] : rob_pkt_q;
    conflict_cnt_d = (!flush && (&ne) && conflict_cnt_q != 8'hFF) ? conflict_cnt_q + 8'd1 : conflict_cnt_q;
  end
  // storage needs no reset: counts and pointers define what is valid
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        cnt_q[s] <= '0;
      end
      rr_q <= 1'b0;
      rob_we_q <= 1'b0;
      rob_src_q <= 1'b0;
      rob_pkt_q <= '0;
      conflict_cnt_q <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr_q[s] <= wr_ptr_d[s];
        rd_ptr_q[s] <= rd_ptr_d[s];
        cnt_q[s] <= cnt_d[s];
      end
      rr_q <= rr_d;
      rob_we_q <= rob_we_d;
      rob_src_q <= rob_src_d;
      rob_pkt_q <= rob_pkt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end
  assign sp_ready = ready[0];
  assign lp_ready = ready[1];
  assign rob_we = rob_we_q;
  assign rob_src = rob_src_q;
  assign rob_pkt = rob_pkt_q;
  assign conflict_cnt = conflict_cnt_q;
endmodule

// File: tb/tb_rob_wr_arbiter.sv
// tb_rob_wr_arbiter: scoreboard bench for the ROB write arbiter
module tb_rob_wr_arbiter;
  localparam int W = 41;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sp_valid = 1'b0, lp_valid = 1'b0, flush = 1'b0;
  logic [W-1:0] sp_pkt = '0, lp_pkt = '0;
  logic sp_ready, lp_ready, rob_we, rob_src;
  logic [W-1:0] rob_pkt;
  logic [7:0] conflict_cnt;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] sp_q [$];
  logic [W-1:0] lp_q [$];
  logic [W-1:0] exp_pkt;
  logic [W-1:0] single_pkt;
  logic exp_we;

  rob_wr_arbiter #(.ROB_REGISTER_SIZE(W), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .sp_valid(sp_valid), .sp_pkt(sp_pkt), .sp_ready(sp_ready),
    .lp_valid(lp_valid), .lp_pkt(lp_pkt), .lp_ready(lp_ready),
    .flush(flush),
    .rob_we(rob_we), .rob_pkt(rob_pkt), .rob_src(rob_src),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic [2:0] slot, input logic [2:0] addr,
                                      input logic [15:0] result, input logic [15:0] pc,
                                      input logic [1:0] ex, input logic we);
    return {slot, addr, result, pc, ex, we};
  endfunction

  function automatic logic [W-1:0] rnd();
    return W'({$urandom(), $urandom()});
  endfunction

  // scoreboard: accepted packets are queued per source, every ROB write must match its head
  always @(negedge clk) begin
    if (rob_we) begin
      checks++;
      if ((rob_src ? lp_q.size() : sp_q.size()) == 0) begin
        errors++;
        $display("FAIL sb_extra_write src=%0d got=%h expected=none", rob_src, rob_pkt);
      end else begin
        exp_pkt = rob_src ? lp_q.pop_front() : sp_q.pop_front();
        if (rob_pkt !== exp_pkt) begin
          errors++;
          $display("FAIL sb_pkt src=%0d got=%h expected=%h", rob_src, rob_pkt, exp_pkt);
        end
      end
    end
    if (!reset || flush) begin
      sp_q.delete();
      lp_q.delete();
    end else begin
      if (sp_valid && sp_ready) sp_q.push_back(sp_pkt);
      if (lp_valid && lp_ready) lp_q.push_back(lp_pkt);
    end
  end

  task automatic test_reset();
    #1;
    checks++; if (rob_we !== 1'b0) begin errors++; $display("FAIL rst_we got=%b expected=0", rob_we); end
    checks++; if (rob_pkt !== '0) begin errors++; $display("FAIL rst_pkt got=%h expected=0", rob_pkt); end
    checks++; if (rob_src !== 1'b0) begin errors++; $display("FAIL rst_src got=%b expected=0", rob_src); end
    checks++; if (conflict_cnt !== 8'd0) begin errors++; $display("FAIL rst_conflict got=%0d expected=0", conflict_cnt); end
    checks++; if ({sp_ready, lp_ready} !== 2'b11) begin errors++; $display("FAIL rst_ready got=%b expected=11", {sp_ready, lp_ready}); end
    @(posedge clk); #3;
    reset = 1'b1;
  endtask

  task automatic test_single();
    single_pkt = mk(3'd3, 3'd5, 16'hBEEF, 16'h0040, 2'b00, 1'b1);
    @(posedge clk); #1;
    sp_valid = 1'b1; sp_pkt = single_pkt;
    @(posedge clk); #1;
    sp_valid = 1'b0;
    checks++; if (rob_we !== 1'b0) begin errors++; $display("FAIL single_early got=%b expected=0", rob_we); end
    checks++; if (sp_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%b expected=1", sp_ready); end
    @(posedge clk); #1;
    checks++; if (rob_we !== 1'b1) begin errors++; $display("FAIL single_we got=%b expected=1", rob_we); end
    checks++; if (rob_src !== 1'b0) begin errors++; $display("FAIL single_src got=%b expected=0", rob_src); end
    checks++; if (rob_pkt !== single_pkt) begin errors++; $display("FAIL single_pkt got=%h expected=%h", rob_pkt, single_pkt); end
    @(posedge clk); #1;
    checks++; if (rob_we !== 1'b0) begin errors++; $display("FAIL single_we_after got=%b expected=0", rob_we); end
    checks++; if (rob_pkt !== single_pkt) begin errors++; $display("FAIL single_hold got=%h expected=%h", rob_pkt, single_pkt); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sp_valid = 1'b1; lp_valid = 1'b1;
    sp_pkt = mk(3'd0, 3'd7, 16'hA000, 16'h0000, 2'b00, 1'b0);
    lp_pkt = rnd();
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      exp_we = (i >= 2 && i <= 11);
      checks++; if (rob_we !== exp_we) begin errors++; $display("FAIL b2b_we cyc=%0d got=%b expected=%b", i, rob_we, exp_we); end
      if (exp_we) begin
        checks++; if (rob_src !== (i % 2 == 1)) begin errors++; $display("FAIL b2b_src cyc=%0d got=%b expected=%b", i, rob_src, (i % 2 == 1)); end
      end
      checks++; if (sp_ready !== !(i >= 3 && i <= 7 && i % 2 == 1)) begin errors++; $display("FAIL b2b_sp_ready cyc=%0d got=%b", i, sp_ready); end
      checks++; if (lp_ready !== !(i >= 2 && i <= 8 && i % 2 == 0)) begin errors++; $display("FAIL b2b_lp_ready cyc=%0d got=%b", i, lp_ready); end
      if (i == 8) begin
        sp_valid = 1'b0; lp_valid = 1'b0;
      end else if (i < 8) begin
        sp_pkt = mk(3'(i), 3'(7 - i), 16'hA000 + 16'(i), 16'(i * 4), 2'(i), 1'(i));
        lp_pkt = rnd();
      end
    end
    checks++; if (conflict_cnt !== 8'd9) begin errors++; $display("FAIL b2b_conflict got=%0d expected=9", conflict_cnt); end
    checks++; if (sp_q.size() + lp_q.size() != 0) begin errors++; $display("FAIL b2b_drain got=%0d left expected=0", sp_q.size() + lp_q.size()); end
  endtask

  task automatic test_fill();
    @(posedge clk); #1;
    lp_valid = 1'b1; lp_pkt = rnd();
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      exp_we = (i >= 2 && i <= 5);
      checks++; if (rob_we !== exp_we) begin errors++; $display("FAIL fill_we cyc=%0d got=%b expected=%b", i, rob_we, exp_we); end
      if (exp_we) begin
        checks++; if (rob_src !== 1'b1) begin errors++; $display("FAIL fill_src cyc=%0d got=%b expected=1", i, rob_src); end
      end
      checks++; if (lp_ready !== 1'b1) begin errors++; $display("FAIL fill_lp_ready cyc=%0d got=%b expected=1", i, lp_ready); end
      lp_pkt = rnd();
      if (i == 4) lp_valid = 1'b0;
    end
    checks++; if (conflict_cnt !== 8'd9) begin errors++; $display("FAIL fill_conflict got=%0d expected=9", conflict_cnt); end
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    sp_valid = 1'b1; lp_valid = 1'b1; sp_pkt = rnd(); lp_pkt = rnd();
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      sp_pkt = rnd(); lp_pkt = rnd();
    end
    checks++; if (rob_we !== 1'b1) begin errors++; $display("FAIL flush_pre_we got=%b expected=1", rob_we); end
    checks++; if (conflict_cnt !== 8'd11) begin errors++; $display("FAIL flush_pre_conflict got=%0d expected=11", conflict_cnt); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; sp_valid = 1'b0; lp_valid = 1'b0;
    checks++; if (rob_we !== 1'b0) begin errors++; $display("FAIL flush_we got=%b expected=0", rob_we); end
    checks++; if ({sp_ready, lp_ready} !== 2'b11) begin errors++; $display("FAIL flush_ready got=%b expected=11", {sp_ready, lp_ready}); end
    checks++; if (conflict_cnt !== 8'd11) begin errors++; $display("FAIL flush_conflict_hold got=%0d expected=11", conflict_cnt); end
    @(posedge clk); #1;
    checks++; if (rob_we !== 1'b0) begin errors++; $display("FAIL flush_idle_we got=%b expected=0", rob_we); end
    sp_valid = 1'b1; lp_valid = 1'b1; sp_pkt = rnd(); lp_pkt = rnd();
    @(posedge clk); #1;
    sp_valid = 1'b0; lp_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if ({rob_we, rob_src} !== 2'b10) begin errors++; $display("FAIL flush_rr_first got=%b expected=10", {rob_we, rob_src}); end
    @(posedge clk); #1;
    checks++; if ({rob_we, rob_src} !== 2'b11) begin errors++; $display("FAIL flush_rr_second got=%b expected=11", {rob_we, rob_src}); end
    checks++; if (conflict_cnt !== 8'd12) begin errors++; $display("FAIL flush_conflict_after got=%0d expected=12", conflict_cnt); end
    @(posedge clk); #1;
    checks++; if (rob_we !== 1'b0) begin errors++; $display("FAIL flush_end_we got=%b expected=0", rob_we); end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    sp_valid = 1'b1; lp_valid = 1'b1; sp_pkt = rnd(); lp_pkt = rnd();
    @(posedge clk); #1;
    sp_pkt = rnd(); lp_pkt = rnd();
    @(posedge clk); #1;
    sp_valid = 1'b0; lp_valid = 1'b0;
    checks++; if (rob_we !== 1'b1) begin errors++; $display("FAIL arst_pre_we got=%b expected=1", rob_we); end
    checks++; if (conflict_cnt !== 8'd13) begin errors++; $display("FAIL arst_pre_conflict got=%0d expected=13", conflict_cnt); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if ({rob_we, rob_src} !== 2'b00) begin errors++; $display("FAIL arst_we_src got=%b expected=00", {rob_we, rob_src}); end
    checks++; if (rob_pkt !== '0) begin errors++; $display("FAIL arst_pkt got=%h expected=0", rob_pkt); end
    checks++; if (conflict_cnt !== 8'd0) begin errors++; $display("FAIL arst_conflict got=%0d expected=0", conflict_cnt); end
    checks++; if ({sp_ready, lp_ready} !== 2'b11) begin errors++; $display("FAIL arst_ready got=%b expected=11", {sp_ready, lp_ready}); end
    @(posedge clk); #3;
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      checks++; if (rob_we !== 1'b0) begin errors++; $display("FAIL arst_after_we cyc=%0d got=%b expected=0", i, rob_we); end
    end
  endtask

  task automatic test_saturate();
    @(posedge clk); #1;
    sp_valid = 1'b1; lp_valid = 1'b1; sp_pkt = rnd(); lp_pkt = rnd();
    for (int i = 1; i <= 310; i++) begin
      @(posedge clk); #1;
      sp_pkt = rnd(); lp_pkt = rnd();
      if (i == 100) begin
        checks++; if (conflict_cnt !== 8'd99) begin errors++; $display("FAIL sat_mid got=%0d expected=99", conflict_cnt); end
      end
      if (i == 300) begin
        checks++; if (conflict_cnt !== 8'd255) begin errors++; $display("FAIL sat_reach got=%0d expected=255", conflict_cnt); end
      end
    end
    checks++; if (conflict_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold got=%0d expected=255", conflict_cnt); end
    sp_valid = 1'b0; lp_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (rob_we !== 1'b0) begin errors++; $display("FAIL sat_drain_we got=%b expected=0", rob_we); end
    checks++; if (sp_q.size() + lp_q.size() != 0) begin errors++; $display("FAIL sat_drain got=%0d left expected=0", sp_q.size() + lp_q.size()); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_flush();
    test_async_reset();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
